uart_tx_dev: RTL and testbench

Memory-mapped UART transmitter peripheral on the system bridge, alongside the two timer devices. The bridge decodes the device base address and presents word address, write enable and write data. Firmware queues bytes into a small FIFO; the block serialises them as 8N1 frames on `txd`. It raises a level interrupt for the CPU's hardware-interrupt vector when the transmitter drains.

---
 rtl/uart_tx_dev.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO; a pushed byte reaches the line one cycle after its write.
// Pushes into a full FIFO are dropped and flagged in the sticky OVF bit; no bus stall is ever applied.
module uart_tx_dev #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        txd
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic              en, ie, ovf;
   logic [15:0]       div_reg;
   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;

   state_t            state_q, state_d;
   logic [15:0]       baud_cnt, baud_cnt_d;
   logic [15:0]       div_lat, div_lat_d;
   logic [2:0]        bit_idx, bit_idx_d;
   logic [7:0]        shift, shift_d;
   logic              txd_d;

   logic              wr_ctrl, wr_div, push, push_ok, pop;
   logic              full, empty, busy, bit_end;
   logic [15:0]       div_eff;
   logic [31:0]       status;
   logic              bus_unused;

   assign bus_unused = &{1'b0, Addr[29:2], Din[31:16]};

   assign wr_ctrl = WE && (Addr[1:0] == 2'd0);
   assign wr_div  = WE && (Addr[1:0] == 2'd1);
   assign push    = WE && (Addr[1:0] == 2'd2);

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign busy    = (state_q != S_IDLE);
   assign push_ok = push && (!full || pop);

   assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;
   assign bit_end = (baud_cnt == div_lat - 16'd1);

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt + 16'd1;
      div_lat_d  = div_lat;
      bit_idx_d  = bit_idx;
      shift_d    = shift;
      pop        = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_cnt_d = 16'd0;
            if (en && !empty) begin
               pop       = 1'b1;
               shift_d   = mem[rd_ptr];
               div_lat_d = div_eff;
               bit_idx_d = 3'd0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_cnt_d = 16'd0;
               state_d    = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_cnt_d = 16'd0;
               shift_d    = {1'b0, shift[7:1]};
               bit_idx_d  = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
                  state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_cnt_d = 16'd0;
               // Chain directly into the next start bit so back-to-back frames have no idle gap.
               if (en && !empty) begin
                  pop       = 1'b1;
                  shift_d   = mem[rd_ptr];
                  div_lat_d = div_eff;
                  bit_idx_d = 3'd0;
                  state_d   = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= Din[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en       <= 1'b0;
         ie       <= 1'b0;
         ovf      <= 1'b0;
         div_reg  <= DEFAULT_DIV;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         state_q  <= S_IDLE;
         baud_cnt <= 16'd0;
         div_lat  <= 16'd1;
         bit_idx  <= 3'd0;
         shift    <= 8'd0;
         txd      <= 1'b1;
      end else begin
         if (wr_ctrl) begin
            en  <= Din[0];
            ie  <= Din[1];
            ovf <= 1'b0;
         end else if (push && !push_ok) begin
            ovf <= 1'b1;
         end
         if (wr_div)
            div_reg <= Din[15:0];
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         state_q  <= state_d;
         baud_cnt <= baud_cnt_d;
         div_lat  <= div_lat_d;
         bit_idx  <= bit_idx_d;
         shift    <= shift_d;
         txd      <= txd_d;
      end
   end

   always_comb begin
      status      = 32'd0;
      status[0]   = busy;
      status[1]   = full;
      status[2]   = empty;
      status[5:3] = 3'(count);
      status[6]   = ovf;
   end

   always_comb begin
      case (Addr[1:0])
         2'd0:    Dout = {30'd0, ie, en};
         2'd1:    Dout = {16'd0, div_reg};
         2'd3:    Dout = status;
         default: Dout = 32'd0;
      endcase
   end

   assign IRQ = ie && empty && !busy;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register map, frame timing, FIFO overflow, IRQ and reset behaviour.
module tb_uart_tx_dev;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [29:0] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;
   logic        txd;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_dev #(.FIFO_DEPTH(4), .DEFAULT_DIV(16'd868)) dut (
      .clk  (clk),
      .reset(reset),
      .Addr (Addr),
      .WE   (WE),
      .Din  (Din),
      .Dout (Dout),
      .IRQ  (IRQ),
      .txd  (txd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      Addr = {28'd0, a};
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      Addr = {28'd0, a};
      #1;
      d = Dout;
   endtask

   function automatic logic fbit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   // Call just after the edge that starts the start bit; returns on the last stop-bit cycle.
   task automatic frame_chk(input logic [7:0] b, input int d, input string tag);
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < d; c++) begin
            @(negedge clk);
            if (c == d / 2)
               chk($sformatf("%s_bit%0d", tag, j), {31'd0, txd}, {31'd0, fbit(b, j)});
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int          busy_cnt;
      logic [7:0]  seq [4];

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_txd_held", {31'd0, txd}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      rd(2'd3, r); chk("rst_status", r, 32'h4);
      rd(2'd1, r); chk("rst_div", r, 32'd868);
      rd(2'd0, r); chk("rst_ctrl", r, 32'd0);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_irq", {31'd0, IRQ}, 32'd0);

      // Single frame A5 at 4 cycles/bit, BUSY exactly 40 cycles
      wr(2'd1, 32'd4);
      wr(2'd0, 32'd1);
      rd(2'd0, r); chk("ctrl_readback", r, 32'd1);
      wr(2'd2, 32'hA5);
      rd(2'd3, r); chk("a5_status_queued", r, 32'h8);
      @(posedge clk);
      #1;
      rd(2'd3, r); chk("a5_status_start", r, 32'h5);
      chk("a5_txd_fall", {31'd0, txd}, 32'd0);
      busy_cnt = 0;
      fork
         frame_chk(8'hA5, 4, "a5");
         begin
            for (int i = 0; i < 41; i++) begin
               @(negedge clk);
               busy_cnt += int'(Dout[0]);
            end
         end
      join
      chk("a5_busy_cycles", busy_cnt, 32'd40);
      chk("a5_txd_idle", {31'd0, txd}, 32'd1);

      // Overflow with EN=0, then simultaneous push/pop at full, back-to-back drain
      wr(2'd0, 32'd0);
      wr(2'd1, 32'd2);
      for (int i = 1; i <= 5; i++)
         wr(2'd2, i);
      rd(2'd3, r); chk("ovf_status", r, 32'h62);
      wr(2'd0, 32'd1);
      rd(2'd3, r); chk("ovf_cleared", r, 32'h22);
      wr(2'd2, 32'h06);
      rd(2'd3, r); chk("full_push_pop", r, 32'h23);
      seq[0] = 8'h02; seq[1] = 8'h03; seq[2] = 8'h04; seq[3] = 8'h06;
      frame_chk(8'h01, 2, "b2b_01");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         frame_chk(seq[i], 2, $sformatf("b2b_%0h", seq[i]));
      end
      @(posedge clk);
      #1;
      rd(2'd3, r); chk("b2b_done_status", r, 32'h4);
      repeat (6) @(posedge clk);
      #1;
      chk("b2b_no_05", {31'd0, txd}, 32'd1);

      // IRQ around a single DIV=1 frame
      wr(2'd1, 32'd1);
      wr(2'd0, 32'd3);
      chk("irq_before_push", {31'd0, IRQ}, 32'd1);
      wr(2'd2, 32'hFF);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("irq_c%0d", i), {31'd0, IRQ}, {31'd0, i == 11});
         chk($sformatf("ff_txd_c%0d", i), {31'd0, txd},
             {31'd0, (i == 0 || i == 11) ? 1'b1 : fbit(8'hFF, i - 1)});
         @(posedge clk);
         #1;
      end
      wr(2'd0, 32'd1);
      chk("irq_ie_clear", {31'd0, IRQ}, 32'd0);

      // DIV change and EN clear mid-frame
      wr(2'd1, 32'd3);
      wr(2'd2, 32'h3C);
      wr(2'd2, 32'hC3);
      fork
         frame_chk(8'h3C, 3, "mid_3c");
         begin
            wr(2'd1, 32'd7);
            wr(2'd0, 32'd0);
         end
      join
      @(posedge clk);
      #1;
      rd(2'd3, r); chk("en_off_idle", r, 32'h8);
      repeat (5) @(posedge clk);
      #1;
      rd(2'd3, r); chk("en_off_hold", r, 32'h8);
      chk("en_off_txd", {31'd0, txd}, 32'd1);
      wr(2'd0, 32'd1);
      @(posedge clk);
      #1;
      frame_chk(8'hC3, 7, "div7_c3");
      @(posedge clk);
      #1;
      rd(2'd3, r); chk("div7_done", r, 32'h4);

      // Reset during data bit 3
      wr(2'd2, 32'hA5);
      @(posedge clk);
      #1;
      repeat (30) @(posedge clk);
      #1;
      chk("pre_rst_txd_bit3", {31'd0, txd}, 32'd0);
      rd(2'd3, r); chk("pre_rst_busy", r, 32'h5);
      reset = 1'b0;
      #1;
      chk("rst_async_txd", {31'd0, txd}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      rd(2'd3, r); chk("post_rst_status", r, 32'h4);
      rd(2'd1, r); chk("post_rst_div", r, 32'd868);
      chk("post_rst_irq", {31'd0, IRQ}, 32'd0);
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_txd", {31'd0, txd}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
